// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: bus widths, chip-enable levels and sequencer states.
package if_fetch_ctrl_pkg;

    localparam int          INST_ADDR_BUS = 32;
    localparam int          INST_BUS      = 32;
    localparam logic        CHIP_ENABLE   = 1'b1;
    localparam logic        CHIP_DISABLE  = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [31:0] IF_PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        IF_ST_BOOT    = 2'd0,
        IF_ST_FETCH   = 2'd1,
        IF_ST_STALLED = 2'd2
    } if_state_e;

    // Instruction addresses are word aligned; low bits of redirect targets are dropped.
    function automatic logic [INST_ADDR_BUS-1:0] word_align(input logic [INST_ADDR_BUS-1:0] a);
        return {a[INST_ADDR_BUS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: squash clears to a bubble, hold freezes, otherwise loads a valid fetch.
module if_id_reg
    import if_fetch_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_hold,
    input  logic                     i_squash,
    input  logic [INST_ADDR_BUS-1:0] i_pc,
    input  logic [INST_BUS-1:0]      i_inst,
    output logic [INST_ADDR_BUS-1:0] o_id_pc,
    output logic [INST_BUS-1:0]      o_id_inst,
    output logic                     o_id_valid
);

    logic [INST_ADDR_BUS-1:0] r_pc;
    logic [INST_BUS-1:0]      r_inst;
    logic                     r_valid;

    always_ff @(posedge clk) begin
        if (rst || i_squash) begin
            r_pc    <= ZERO_WORD;
            r_inst  <= ZERO_WORD;
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_valid <= 1'b1;
        end
    end

    assign o_id_pc    = r_pc;
    assign o_id_inst  = r_inst;
    assign o_id_valid = r_valid;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, ROM enable, boot delay and stall/flush/branch priority.
// Build option IF_DELAY_SLOT_EN keeps the instruction fetched alongside a branch (delay slot).
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BOOT_DELAY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic [INST_ADDR_BUS-1:0] new_pc_i,
    input  logic                     branch_flag_i,
    input  logic [INST_ADDR_BUS-1:0] branch_target_i,
    input  logic [INST_BUS-1:0]      rom_data_i,
    output logic [INST_ADDR_BUS-1:0] rom_addr_o,
    output logic                     rom_ce_o,
    output logic [INST_ADDR_BUS-1:0] id_pc_o,
    output logic [INST_BUS-1:0]      id_inst_o,
    output logic                     id_valid_o
);

`ifdef IF_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

    if_state_e                r_state;
    logic [3:0]               r_boot_cnt;
    logic [INST_ADDR_BUS-1:0] r_pc;
    logic                     r_ce;

    logic w_running;
    logic w_hold;
    logic w_squash;

    // STALLED differs from FETCH only in name: both apply the same priority each cycle.
    assign w_running = (r_state != IF_ST_BOOT);
    assign w_hold    = w_running && !flush_i && stall_i;
    assign w_squash  = !w_running || flush_i ||
                       (branch_flag_i && !stall_i && !DELAY_SLOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IF_ST_BOOT;
            r_boot_cnt <= 4'd0;
            r_pc       <= RESET_PC;
            r_ce       <= CHIP_DISABLE;
        end else begin
            case (r_state)
                IF_ST_BOOT: begin
                    if (r_boot_cnt == BOOT_LAST) begin
                        r_state    <= IF_ST_FETCH;
                        r_boot_cnt <= 4'd0;
                        r_ce       <= CHIP_ENABLE;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 4'd1;
                    end
                end
                IF_ST_FETCH, IF_ST_STALLED: begin
                    r_ce <= CHIP_ENABLE;
                    if (flush_i) begin
                        r_pc    <= word_align(new_pc_i);
                        r_state <= IF_ST_FETCH;
                    end else if (stall_i) begin
                        r_state <= IF_ST_STALLED;
                    end else if (branch_flag_i) begin
                        r_pc    <= word_align(branch_target_i);
                        r_state <= IF_ST_FETCH;
                    end else begin
                        r_pc    <= r_pc + IF_PC_STEP;
                        r_state <= IF_ST_FETCH;
                    end
                end
                default: begin
                    r_state <= IF_ST_BOOT;
                    r_ce    <= CHIP_DISABLE;
                end
            endcase
        end
    end

    assign rom_addr_o = r_pc;
    assign rom_ce_o   = r_ce;

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .i_hold     (w_hold),
        .i_squash   (w_squash),
        .i_pc       (r_pc),
        .i_inst     (rom_data_i),
        .o_id_pc    (id_pc_o),
        .o_id_inst  (id_inst_o),
        .o_id_valid (id_valid_o)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a cycle-level behavioural model queues expected outputs.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          BOOT_DELAY = 2;

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0, flush_i = 1'b0, branch_flag_i = 1'b0;
    logic [31:0] new_pc_i = '0, branch_target_i = '0;
    logic [31:0] rom_data_i;
    logic [31:0] rom_addr_o, id_pc_o, id_inst_o;
    logic        rom_ce_o, id_valid_o;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h3401_4000 ^ (a * 32'h9E37_79B1);
    endfunction

    assign rom_data_i = rom(rom_addr_o);

    if_fetch_ctrl #(.RESET_PC(RESET_PC), .BOOT_DELAY(BOOT_DELAY)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i), .rom_data_i(rom_data_i),
        .rom_addr_o(rom_addr_o), .rom_ce_o(rom_ce_o), .id_pc_o(id_pc_o),
        .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        ce;
        logic [31:0] idpc;
        logic [31:0] inst;
        logic        v;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: boot countdown, then the four-way redirect priority on a plain PC.
    int          m_boot = 0;
    logic [31:0] m_pc = '0, m_idpc = '0, m_inst = '0;
    logic        m_ce = 1'b0, m_v = 1'b0;

    task automatic model(input bit rs, st, fl, input logic [31:0] np, input bit br, input logic [31:0] bt);
        exp_t e;
        if (rs) begin
            m_pc = RESET_PC; m_boot = BOOT_DELAY; m_ce = 1'b0;
            m_idpc = 0; m_inst = 0; m_v = 1'b0;
        end else if (m_boot > 0) begin
            m_boot = m_boot - 1;
            m_ce = (m_boot == 0);
            m_idpc = 0; m_inst = 0; m_v = 1'b0;
        end else if (fl) begin
            m_idpc = 0; m_inst = 0; m_v = 1'b0;
            m_pc = np & 32'hFFFF_FFFC;
        end else if (st) begin
            // everything holds
        end else if (br) begin
            if (DS) begin m_idpc = m_pc; m_inst = rom(m_pc); m_v = 1'b1; end
            else    begin m_idpc = 0;    m_inst = 0;         m_v = 1'b0; end
            m_pc = bt & 32'hFFFF_FFFC;
        end else begin
            m_idpc = m_pc; m_inst = rom(m_pc); m_v = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        e.addr = m_pc; e.ce = m_ce; e.idpc = m_idpc; e.inst = m_inst; e.v = m_v;
        q.push_back(e);
    endtask

    task automatic step(input bit rs, st, fl, input logic [31:0] np, input bit br, input logic [31:0] bt);
        @(negedge clk);
        rst = rs; stall_i = st; flush_i = fl; new_pc_i = np;
        branch_flag_i = br; branch_target_i = bt;
        model(rs, st, fl, np, br, bt);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    // Monitor: every edge with an outstanding expectation is compared field by field.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rom_addr", rom_addr_o, e.addr);
            chk("rom_ce", {31'b0, rom_ce_o}, {31'b0, e.ce});
            chk("id_pc", id_pc_o, e.idpc);
            chk("id_inst", id_inst_o, e.inst);
            chk("id_valid", {31'b0, id_valid_o}, {31'b0, e.v});
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0);
        #1 chk("reset_ce", {31'b0, rom_ce_o}, 32'd0);
        idle(1);
        #1 chk("boot_ce_low", {31'b0, rom_ce_o}, 32'd0);
        idle(1);
        #1 chk("boot_done_ce", {31'b0, rom_ce_o}, 32'd1);
        idle(1);
        #1 chk("first_inst", id_inst_o, 32'h3401_4000);
        idle(2);
        #1 chk("addr_0c", rom_addr_o, 32'h0000_000C);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 32'h0000_0100);
        #1 chk("stall_addr", rom_addr_o, 32'h0000_000C);
        idle(1);
        #1 chk("post_stall_idpc", id_pc_o, 32'h0000_000C);
        idle(4);
        step(0, 0, 0, 0, 1, 32'h0000_0048);
        #1 chk("branch_addr", rom_addr_o, 32'h0000_0048);
        chk("branch_valid", {31'b0, id_valid_o}, {31'b0, DS});
        step(0, 1, 1, 32'h0000_0070, 1, 32'h0000_0200);
        #1 chk("flush_addr", rom_addr_o, 32'h0000_0070);
        idle(2);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        #1 chk("rst_mid_stall_ce", {31'b0, rom_ce_o}, 32'd0);
        idle(2);
        step(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        #1 chk("wrap_hi", rom_addr_o, 32'hFFFF_FFFC);
        idle(1);
        #1 chk("wrap_lo", rom_addr_o, 32'h0000_0000);

        for (int i = 0; i < 600; i++) begin
            bit rs, st, fl, br;
            logic [31:0] np, bt;
            rs = ($urandom_range(99) < 2);
            st = ($urandom_range(99) < 25);
            fl = ($urandom_range(99) < 8);
            br = ($urandom_range(99) < 15);
            np = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            bt = $urandom;
            step(rs, st, fl, np, br, bt);
        end
        idle(2);
        repeat (2) @(posedge clk);
        #2 chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer between pipeline control and the combinational instruction ROM.
- Owns the PC, drives the ROM address and chip enable, and registers the fetched word into the IF/ID pipeline register.
- Applies stall, flush (exception redirect) and branch redirect in a fixed priority order.
- ROM read is combinational: data for the current rom_addr_o arrives in the same cycle.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BOOT_DELAY, 2, cycles with the ROM disabled after reset deasserts (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall_i  in  1  pipeline stall request for IF and ID.
- flush_i  in  1  exception flush.
- new_pc_i  in  32  flush target.
- branch_flag_i  in  1  branch/jump resolved in ID.
- branch_target_i  in  32  branch target.
- rom_data_i  in  32  instruction from ROM.
- rom_addr_o  out  32  ROM address (equals PC).
- rom_ce_o  out  1  ROM chip enable (CHIP_ENABLE/CHIP_DISABLE).
- id_pc_o  out  32  PC of the instruction held in IF/ID.
- id_inst_o  out  32  instruction held in IF/ID.
- id_valid_o  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset: all outputs go to reset values on the first rising clk with rst=1.
  - rom_ce_o=CHIP_DISABLE, rom_addr_o=RESET_PC, id_pc_o=0, id_inst_o=ZERO_WORD, id_valid_o=0.
  - State goes to BOOT and the boot counter clears.
  - rst mid-operation overrides every other input in that cycle.
- State BOOT:
  - rom_ce_o=0, PC held at RESET_PC, IF/ID loaded with ZERO_WORD and valid=0.
  - After BOOT_DELAY cycles, move to FETCH.
  - flush_i, stall_i and branch_flag_i are ignored.
- State FETCH: rom_ce_o=1. Each cycle the following are evaluated in priority order:
  1. flush_i=1: PC<=new_pc_i; IF/ID<=ZERO_WORD, valid=0, id_pc_o=0. Flush wins over a simultaneous stall or branch.
  2. stall_i=1: PC and IF/ID hold. Go to STALLED. branch_flag_i is ignored; ID re-presents it after the stall.
  3. branch_flag_i=1: PC<=branch_target_i. IF/ID handling of the current fetch depends on DELAY_SLOT_EN (see Optional Feature).
  4. Otherwise: IF/ID<=(PC, rom_data_i, valid=1); PC<=PC+4.
- State STALLED:
  - rom_ce_o stays 1 and PC/IF/ID hold.
  - Return to FETCH on the first cycle with stall_i=0; that cycle is evaluated with the FETCH rules.
  - flush_i in STALLED applies the flush action and returns to FETCH.
- PC arithmetic:
  - 32-bit, wraps 32'hFFFF_FFFC -> 0.
  - Bits [1:0] of new_pc_i and branch_target_i are forced to 0.
- Disabled ROM: any instruction captured while rom_ce_o=0 is ZERO_WORD with valid=0.
- Latency: instruction at address A appears on id_inst_o one cycle after rom_addr_o=A, absent stall.

Optional Feature:
- Macro IF_DELAY_SLOT_EN.
- Defined: on branch, the instruction fetched that cycle (PC, rom_data_i) is loaded into IF/ID with valid=1 (MIPS delay slot).
- Undefined: that instruction is squashed; IF/ID<=ZERO_WORD, valid=0, id_pc_o=0.
- Flush behaviour is identical in both builds.

Decomposition:
- Shared DEFINE package gains:
  - state encodings IF_ST_BOOT, IF_ST_FETCH, IF_ST_STALLED;
  - IF_PC_STEP (4);
  - reuse of INST_ADDR_BUS, INST_BUS, CHIP_ENABLE/CHIP_DISABLE, ZERO_WORD.
- One natural sub-module: if_id_reg (the IF/ID register with hold/squash controls). The FSM and PC stay in if_fetch_ctrl.

Test Plan:
- Reset release, BOOT_DELAY=2 -> rom_ce_o=0 for 2 cycles, then 1. rom_addr_o sequence 0,4,8; id_inst_o after address 0 = 32'h34014000, valid=1.
- stall_i high 3 cycles while rom_addr_o=0x0C -> rom_addr_o, id_pc_o and id_inst_o frozen for 3 cycles; next cycle id_pc_o=0x0C, rom_addr_o=0x10.
- branch_flag_i=1, branch_target_i=0x48 while rom_addr_o=0x20:
  - with IF_DELAY_SLOT_EN: next id_pc_o=0x20, valid=1, then rom_addr_o=0x48;
  - without: id_inst_o=0, valid=0.
- flush_i, stall_i and branch_flag_i all high, new_pc_i=0x70 -> rom_addr_o=0x70, id_valid_o=0, state FETCH.
- rst asserted mid-stall -> next edge: all outputs at reset values, rom_ce_o=0, BOOT repeats.
- new_pc_i=0xFFFF_FFFE -> rom_addr_o=0xFFFF_FFFC, then wraps to 0x0000_0000.
